// File: rtl/mips_instr_encoder_if.sv
// Request/response bundle for the MIPS instruction encoder.
// The master drives the field request and consumes encoded words.
// The slave (the encoder) accepts requests and presents encoded words.
interface mips_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_illegal;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_illegal
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_illegal
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs R/I/J field requests into 32-bit words,
// tags each with a sequential address and queues them in a DEPTH-entry FIFO.
// An accepted request first lands in a one-entry staging register and is
// written to the FIFO on the following edge, so there is no bypass path.
// count_q tracks total occupancy (staged + stored) so in_ready reserves room
// for the staged word.
// Optional feature: define MIPS_ENC_FIELD_CHECK_EN to drop requests with an
// illegal format/opcode combination and pulse err_illegal for each drop.
// DEPTH must be a power of two and at least 2.
module mips_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    mips_instr_encoder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   addr_q, addr_d;
    logic          pend_v_q, pend_v_d;
    logic [31:0]   pend_instr_q, pend_instr_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          err_q, err_d;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_addr  [DEPTH];

    logic [31:0]   enc_word;
    logic          legal;
    logic          acc;
    logic          push;
    logic          pop;
    logic          mem_we;

    // Field packing; format 3 falls back to the R layout
    always_comb begin
        enc_word = '0;
        unique case (bus.in_fmt)
            2'd1:    enc_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
            2'd2:    enc_word = {bus.in_opcode, bus.in_target};
            default: enc_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd,
                                 bus.in_shamt, bus.in_funct};
        endcase
    end

    // Legality of the request's format/opcode pair
    always_comb begin
`ifdef MIPS_ENC_FIELD_CHECK_EN
        legal = 1'b0;
        unique case (bus.in_fmt)
            2'd0:    legal = (bus.in_opcode == 6'd0);
            2'd1:    legal = !(bus.in_opcode == 6'd0 || bus.in_opcode == 6'd2 ||
                               bus.in_opcode == 6'd3);
            2'd2:    legal = (bus.in_opcode == 6'd2 || bus.in_opcode == 6'd3);
            default: legal = 1'b0;
        endcase
`else
        legal = 1'b1;
`endif
    end

    // Next-state for occupancy, pointers, address counter and staging register
    always_comb begin
        acc          = bus.in_valid && in_ready_q;
        push         = acc && legal && !clr;
        pop          = bus.out_ready && out_valid_q && !clr;
        mem_we       = pend_v_q && !clr;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        addr_d       = addr_q;
        pend_v_d     = 1'b0;
        pend_instr_d = pend_instr_q;
        pend_addr_d  = pend_addr_q;
        out_valid_d  = 1'b0;
        in_ready_d   = 1'b0;
        err_d        = 1'b0;
        if (clr) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            addr_d   = BASE_ADDR;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) begin
                addr_d       = addr_q + 32'd4;
                pend_instr_d = enc_word;
                pend_addr_d  = addr_q;
            end
            pend_v_d    = push;
            // Visible words exclude the one sitting in the staging register
            out_valid_d = (count_d != CW'(pend_v_d));
            in_ready_d  = (count_d != FULL);
`ifdef MIPS_ENC_FIELD_CHECK_EN
            err_d       = acc && !legal;
`endif
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            addr_q       <= BASE_ADDR;
            pend_v_q     <= 1'b0;
            pend_instr_q <= '0;
            pend_addr_q  <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            addr_q       <= addr_d;
            pend_v_q     <= pend_v_d;
            pend_instr_q <= pend_instr_d;
            pend_addr_q  <= pend_addr_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_instr[wr_ptr_q] <= pend_instr_q;
            mem_addr[wr_ptr_q]  <= pend_addr_q;
        end
    end

    // Outputs; an empty FIFO shows a zero word and the next address
    always_comb begin
        bus.in_ready    = in_ready_q;
        bus.out_valid   = out_valid_q;
        bus.err_illegal = err_q;
        bus.out_instr   = out_valid_q ? mem_instr[rd_ptr_q] : 32'h0;
        bus.out_addr    = out_valid_q ? mem_addr[rd_ptr_q]  : addr_q;
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed testbench for mips_instr_encoder (DEPTH=4, default base address).
module tb_mips_instr_encoder;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] BASE = 32'h0040_0000;

    mips_instr_encoder_if bus ();

    mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for exactly one edge; caller ensures in_ready is high
    task automatic issue(input logic [1:0] f, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tgt);
        bus.in_fmt    = f;
        bus.in_opcode = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_shamt  = sh;
        bus.in_funct  = fn;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    // After issue() with out_ready=1: not visible yet, visible next cycle, then popped
    task automatic expect_word(input string tag, input logic [31:0] instr,
                               input logic [31:0] addr);
        chk1({tag, "_nobypass"}, bus.out_valid, 1'b0);
        step();
        chk1({tag, "_valid"}, bus.out_valid, 1'b1);
        chk32({tag, "_instr"}, bus.out_instr, instr);
        chk32({tag, "_addr"}, bus.out_addr, addr);
        step();
        chk1({tag, "_popped"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        int   accepted;
        int   got;
        logic acc;

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_fmt    = 2'd0;
        bus.in_opcode = 6'd0;
        bus.in_funct  = 6'd0;
        bus.in_rs     = 5'd0;
        bus.in_rt     = 5'd0;
        bus.in_rd     = 5'd0;
        bus.in_shamt  = 5'd0;
        bus.in_imm    = 16'd0;
        bus.in_target = 26'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_err", bus.err_illegal, 1'b0);
        chk32("rst_out_instr", bus.out_instr, 32'h0);
        chk32("rst_out_addr", bus.out_addr, 32'h0040_0000);

        rst = 1'b0;
        step();
        chk1("release_in_ready", bus.in_ready, 1'b1);

        // Single R / I / J / shift requests, consumer always ready
        bus.out_ready = 1'b1;
        issue(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        expect_word("r_add", 32'h0022_1820, 32'h0040_0000);
        issue(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0);
        expect_word("i_addi", 32'h2022_FFFF, 32'h0040_0004);
        issue(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h010_0000);
        expect_word("j_jump", 32'h0810_0000, 32'h0040_0008);
        issue(2'd0, 6'h00, 5'd0, 5'd5, 5'd4, 5'd2, 6'h00, 16'h0, 26'h0);
        expect_word("r_sll", 32'h0005_2080, 32'h0040_000C);

        // Reserved format
        issue(2'd3, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
`ifdef MIPS_ENC_FIELD_CHECK_EN
        chk1("fmt3_err_pulse", bus.err_illegal, 1'b1);
        chk1("fmt3_no_store0", bus.out_valid, 1'b0);
        step();
        chk1("fmt3_err_once", bus.err_illegal, 1'b0);
        chk1("fmt3_no_store1", bus.out_valid, 1'b0);
        issue(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0001, 26'h0);
        expect_word("after_drop", 32'h2022_0001, 32'h0040_0010);
`else
        chk1("fmt3_no_err", bus.err_illegal, 1'b0);
        expect_word("fmt3_rlayout", 32'h0022_1820, 32'h0040_0010);
`endif

        // Clear overrides a simultaneous push and restarts addressing
        clr = 1'b1;
        bus.in_fmt    = 2'd1;
        bus.in_opcode = 6'h08;
        bus.in_valid  = 1'b1;
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk1("clr_in_ready_low", bus.in_ready, 1'b0);
        chk1("clr_out_valid0", bus.out_valid, 1'b0);
        step();
        chk1("clr_in_ready_back", bus.in_ready, 1'b1);
        chk1("clr_push_dropped", bus.out_valid, 1'b0);

        // Five back-to-back I requests with the consumer stalled
        bus.out_ready = 1'b0;
        bus.in_fmt    = 2'd1;
        bus.in_opcode = 6'h08;
        bus.in_rs     = 5'd1;
        bus.in_rt     = 5'd2;
        bus.in_imm    = 16'd0;
        bus.in_valid  = 1'b1;
        accepted = 0;
        for (int c = 0; c < 20 && accepted < 4; c++) begin
            acc = bus.in_ready;
            step();
            if (acc) begin
                accepted++;
                bus.in_imm = 16'(accepted);
            end
        end
        chk32("burst_four_accepted", 32'(accepted), 32'd4);
        chk1("burst_full_not_ready", bus.in_ready, 1'b0);
        repeat (2) step();
        chk1("burst_fifth_stalls", bus.in_ready, 1'b0);
        chk32("burst_head_instr_hold", bus.out_instr, 32'h2022_0000);
        chk32("burst_head_addr_hold", bus.out_addr, 32'h0040_0000);

        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (bus.out_valid) begin
                chk32("burst_instr", bus.out_instr, 32'h2022_0000 + 32'(got));
                chk32("burst_addr", bus.out_addr, 32'h0040_0000 + 32'(4 * got));
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) bus.in_valid = 1'b0;
        end
        chk32("burst_drained", 32'(got), 32'd5);
        bus.in_valid = 1'b0;

        // Reset asserted mid-stream with three entries stored
        bus.out_ready = 1'b0;
        repeat (2) step();
        issue(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0);
        issue(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0011, 26'h0);
        issue(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0012, 26'h0);
        step();
        chk1("pre_rst_valid", bus.out_valid, 1'b1);
        chk32("pre_rst_addr", bus.out_addr, 32'h0040_0014);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_out_valid", bus.out_valid, 1'b0);
        chk1("async_rst_in_ready", bus.in_ready, 1'b0);
        chk32("async_rst_out_instr", bus.out_instr, 32'h0);
        chk32("async_rst_out_addr", bus.out_addr, 32'h0040_0000);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        chk1("post_rst_empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        issue(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        expect_word("post_rst_word", 32'h0022_1820, 32'h0040_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_instr_encoder.md
MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter BASE_ADDR, default 32'h0040_0000: address given to the first encoded word after reset or clear.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of FIFO contents and the address counter.
REQ-006 in_valid  input  1  a field request is present.
REQ-007 in_ready  output  1  the encoder can accept a request this cycle.
REQ-008 in_fmt  input  2  format: 0=R, 1=I, 2=J, 3=reserved.
REQ-009 in_opcode  input  6; in_funct  input  6; in_rs, in_rt, in_rd, in_shamt  input  5 each: instruction fields.
REQ-010 in_imm  input  16; in_target  input  26: immediate and jump-target fields.
REQ-011 out_valid  output  1  FIFO head holds an encoded word.
REQ-012 out_ready  input  1  the consumer takes the head word.
REQ-013 out_instr  output  32  encoded instruction word at the FIFO head.
REQ-014 out_addr  output  32  address assigned to out_instr.
REQ-015 err_illegal  output  1  one-cycle pulse when a request is dropped.

Function
REQ-016 Transfers SHALL occur only on cycles with valid and ready both high; in_valid SHALL NOT depend on in_ready.
REQ-017 R format SHALL encode {opcode, rs, rt, rd, shamt, funct}.
REQ-018 I format SHALL encode {opcode, rs, rt, imm}.
REQ-019 J format SHALL encode {opcode, target}.
REQ-020 in_ready SHALL be a registered value equal to (count != DEPTH).
REQ-021 A push SHALL be refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-022 The encoder SHALL have no bypass path: a request accepted at edge N SHALL appear with out_valid high after edge N+1 when the FIFO was empty.
REQ-023 out_instr and out_addr SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 The FIFO SHALL keep order; pointers SHALL wrap modulo DEPTH; count SHALL range over 0..DEPTH.
REQ-025 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-026 A pop SHALL be ignored when the FIFO is empty.
REQ-027 The address counter SHALL start at BASE_ADDR.
REQ-028 Each stored word SHALL take the current address, and the counter SHALL then increment by 4, wrapping modulo 2^32.
REQ-029 Dropped requests SHALL NOT advance the address counter.
REQ-030 clr SHALL empty the FIFO and load the address counter with BASE_ADDR.
REQ-031 clr SHALL override any push or pop in the same cycle.
REQ-032 When clr is high, in_ready SHALL be low in the following cycle only.

Reset
REQ-033 While rst is high: count = 0; pointers = 0; address counter = BASE_ADDR.
REQ-034 While rst is high: out_valid = 0, in_ready = 0, err_illegal = 0.
REQ-035 While rst is high: out_instr = 32'h0 and out_addr = BASE_ADDR.
REQ-036 in_ready SHALL go high on the first rising edge after rst deasserts.
REQ-037 Reset during operation SHALL discard all FIFO contents with no partial output.

Configuration
REQ-038 Macro MIPS_ENC_FIELD_CHECK_EN defined: a request SHALL be dropped, with err_illegal pulsed on the cycle after acceptance, when any of these holds:
- in_fmt == 3;
- R format with in_opcode != 0;
- I format with in_opcode in {0, 2, 3};
- J format with in_opcode not in {2, 3}.
REQ-039 A dropped request SHALL still complete its handshake: it consumes the accept cycle.
REQ-040 Macro MIPS_ENC_FIELD_CHECK_EN undefined:
- every accepted request SHALL be stored;
- in_fmt == 3 SHALL use the R layout;
- err_illegal SHALL be tied to 0.

Verification
REQ-041 R request (opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 6'h20), out_ready=1 -> next cycle out_instr=32'h0022_1820, out_addr=32'h0040_0000.
REQ-042 I request (opcode 6'h08, rs 1, rt 2, imm 16'hFFFF) -> out_instr=32'h2022_FFFF.
REQ-043 J request (opcode 2, target 26'h010_0000) -> out_instr=32'h0810_0000.
REQ-044 Five back-to-back requests with out_ready=0, DEPTH=4 -> in_ready low after the fourth accept, fifth stalls; then out_ready=1 -> addresses 0x0040_0000, +4, +8, +C, +10 in order.
REQ-045 With the macro defined, a request with in_fmt=3 -> err_illegal pulses once, no word stored, the next valid word gets the unadvanced address.
REQ-046 rst asserted mid-stream with 3 entries stored -> out_valid=0 at once; after release the first new word has out_addr=32'h0040_0000.
